// File: rtl/ins_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ins_pipe
//  Description : Four-stage instruction register chain (decode, execute,
//                memory, writeback) with flush on control-unit squash,
//                optional one-cycle load-use hold, and saturating bubble
//                and flush event counters.
//  Ports       : clk, rst_n (async, active-low)
//                imem_ins/imem_valid  - fetched instruction and its qualifier
//                stall_decode         - squash decode/execute (jump or branch)
//                ins1..ins4           - stage instruction words
//                opcode1..opcode4     - bits [6:0] of each stage word
//                ins2_rs1/ins2_rs2/ins3_rs2, ins3_rd/ins4_rd - register fields
//                fetch_hold           - fetch keeps PC this cycle (comb.)
//                bubble_cnt/flush_cnt - saturating 16-bit event counters
//  Config      : define INS_PIPE_LOAD_USE_STALL_EN to enable load-use hold
//  Revision    : 1.0 - initial release
// ============================================================================
module ins_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_ins,
    input  logic        imem_valid,
    input  logic        stall_decode,
    output logic [31:0] ins1,
    output logic [31:0] ins2,
    output logic [31:0] ins3,
    output logic [31:0] ins4,
    output logic [6:0]  opcode1,
    output logic [6:0]  opcode2,
    output logic [6:0]  opcode3,
    output logic [6:0]  opcode4,
    output logic [4:0]  ins2_rs1,
    output logic [4:0]  ins2_rs2,
    output logic [4:0]  ins3_rs2,
    output logic [4:0]  ins3_rd,
    output logic [4:0]  ins4_rd,
    output logic        fetch_hold,
    output logic [15:0] bubble_cnt,
    output logic [15:0] flush_cnt
);

    // addi x0,x0,0
    localparam logic [31:0] c_NOP     = 32'h0000_0013;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [31:0] ins1_q, ins2_q, ins3_q, ins4_q;
    logic [31:0] ins1_d, ins2_d, ins3_d, ins4_d;
    logic [15:0] bubble_q, bubble_d;
    logic [15:0] flush_q, flush_d;
    logic        w_load_use;

`ifdef INS_PIPE_LOAD_USE_STALL_EN
    logic [4:0] w_ld_rd;
    logic [4:0] w_dec_rs1;
    logic [4:0] w_dec_rs2;
    logic       w_reads_rs1;
    logic       w_reads_rs2;

    assign w_ld_rd   = ins2_q[11:7];
    assign w_dec_rs1 = ins1_q[19:15];
    assign w_dec_rs2 = ins1_q[24:20];

    // Which source fields the instruction in decode actually consumes.
    always_comb begin
        w_reads_rs1 = 1'b0;
        w_reads_rs2 = 1'b0;
        case (ins1_q[6:0])
            7'b0110011,
            7'b0100011,
            7'b1100011: begin
                w_reads_rs1 = 1'b1;
                w_reads_rs2 = 1'b1;
            end
            7'b0010011,
            7'b0000011,
            7'b1100111: w_reads_rs1 = 1'b1;
            default: begin
                w_reads_rs1 = 1'b0;
                w_reads_rs2 = 1'b0;
            end
        endcase
    end

    // A load in execute whose destination is read by decode; x0 never hazards.
    assign w_load_use = (ins2_q[6:0] == 7'b0000011) && (w_ld_rd != 5'd0) &&
                        ((w_reads_rs1 && (w_dec_rs1 == w_ld_rd)) ||
                         (w_reads_rs2 && (w_dec_rs2 == w_ld_rd)));
`else
    // Software is responsible for load-use spacing in this build.
    assign w_load_use = 1'b0;
`endif

    // A flush overrides the hold, so fetch is released when a squash is active.
    assign fetch_hold = w_load_use & ~stall_decode;

    always_comb begin
        ins1_d   = ins1_q;
        ins2_d   = ins1_q;
        ins3_d   = ins2_q;
        ins4_d   = ins3_q;
        bubble_d = bubble_q;
        flush_d  = flush_q;
        if (stall_decode) begin
            ins1_d = c_NOP;
            ins2_d = c_NOP;
            if (flush_q != c_CNT_MAX) begin
                flush_d = flush_q + 16'd1;
            end
        end else if (w_load_use) begin
            // ins1 keeps the dependent instruction; a bubble goes to execute.
            ins2_d = c_NOP;
            if (bubble_q != c_CNT_MAX) begin
                bubble_d = bubble_q + 16'd1;
            end
        end else begin
            ins1_d = imem_valid ? imem_ins : c_NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins1_q   <= c_NOP;
            ins2_q   <= c_NOP;
            ins3_q   <= c_NOP;
            ins4_q   <= c_NOP;
            bubble_q <= 16'd0;
            flush_q  <= 16'd0;
        end else begin
            ins1_q   <= ins1_d;
            ins2_q   <= ins2_d;
            ins3_q   <= ins3_d;
            ins4_q   <= ins4_d;
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end

    assign ins1       = ins1_q;
    assign ins2       = ins2_q;
    assign ins3       = ins3_q;
    assign ins4       = ins4_q;
    assign opcode1    = ins1_q[6:0];
    assign opcode2    = ins2_q[6:0];
    assign opcode3    = ins3_q[6:0];
    assign opcode4    = ins4_q[6:0];
    assign ins2_rs1   = ins2_q[19:15];
    assign ins2_rs2   = ins2_q[24:20];
    assign ins3_rs2   = ins3_q[24:20];
    assign ins3_rd    = ins3_q[11:7];
    assign ins4_rd    = ins4_q[11:7];
    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_ins_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ins_pipe
//  Description : Self-checking bench for ins_pipe: vector table, directed
//                hazard/flush/reset/saturation sequences and a random stream,
//                all scored through an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ins_pipe;

    localparam logic [31:0] c_NOP   = 32'h0000_0013;
    localparam logic [31:0] c_ADDI1 = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] c_ADD2  = 32'h0010_8133; // add  x2,x1,x1
    localparam logic [31:0] c_LW5   = 32'h0000_2283; // lw   x5,0(x0)
    localparam logic [31:0] c_ADD6  = 32'h0002_8333; // add  x6,x5,x0
    localparam logic [31:0] c_LW0   = 32'h0000_2003; // lw   x0,0(x0)
    localparam logic [31:0] c_ADD60 = 32'h0000_0333; // add  x6,x0,x0
    localparam logic [31:0] c_JAL   = 32'h0000_006F; // jal  x0,0
    localparam logic [31:0] c_SW5   = 32'h0050_A023; // sw   x5,0(x1)
    localparam logic [31:0] c_BEQ5  = 32'h0050_0063; // beq  x0,x5,0
    localparam logic [31:0] c_ADDI7 = 32'h0012_8393; // addi x7,x5,1
    localparam logic [31:0] c_JALR5 = 32'h0002_8067; // jalr x0,0(x5)

`ifdef INS_PIPE_LOAD_USE_STALL_EN
    localparam bit c_LU_EN = 1'b1;
`else
    localparam bit c_LU_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_ins;
    logic        imem_valid;
    logic        stall_decode;
    logic [31:0] ins1, ins2, ins3, ins4;
    logic [6:0]  opcode1, opcode2, opcode3, opcode4;
    logic [4:0]  ins2_rs1, ins2_rs2, ins3_rs2, ins3_rd, ins4_rd;
    logic        fetch_hold;
    logic [15:0] bubble_cnt, flush_cnt;

    ins_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_ins     (imem_ins),
        .imem_valid   (imem_valid),
        .stall_decode (stall_decode),
        .ins1         (ins1),
        .ins2         (ins2),
        .ins3         (ins3),
        .ins4         (ins4),
        .opcode1      (opcode1),
        .opcode2      (opcode2),
        .opcode3      (opcode3),
        .opcode4      (opcode4),
        .ins2_rs1     (ins2_rs1),
        .ins2_rs2     (ins2_rs2),
        .ins3_rs2     (ins3_rs2),
        .ins3_rd      (ins3_rd),
        .ins4_rd      (ins4_rd),
        .fetch_hold   (fetch_hold),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i1, i2, i3, i4;
        logic [15:0] bc, fc;
        string       tag;
    } exp_t;

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic        st;
        logic [31:0] e1, e2, e3, e4;
        logic [15:0] fc;
    } vec_t;

    exp_t        sbq[$];
    vec_t        tbl[12];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          hold_seen = 0;
    logic [31:0] m1, m2, m3, m4;
    logic [15:0] mb, mf;
    logic [31:0] pool[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic st,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic [31:0] e3, input logic [31:0] e4,
                                input logic [15:0] fc);
        vec_t r;
        r.v = v; r.ins = ins; r.st = st;
        r.e1 = e1; r.e2 = e2; r.e3 = e3; r.e4 = e4; r.fc = fc;
        return r;
    endfunction

    // Independent statement of the hazard rule: does `dec` read the register
    // loaded by `exe`?
    function automatic logic model_lu(input logic [31:0] dec, input logic [31:0] exe);
        logic [4:0] rd;
        rd = exe[11:7];
        if (!c_LU_EN || exe[6:0] != 7'h03 || rd == 5'd0) return 1'b0;
        case (dec[6:0])
            7'h33, 7'h23, 7'h63: return (dec[19:15] == rd) || (dec[24:20] == rd);
            7'h13, 7'h03, 7'h67: return dec[19:15] == rd;
            default:             return 1'b0;
        endcase
    endfunction

    task automatic drive_cycle(input logic v, input logic [31:0] ins, input logic st,
                               input exp_t e, input logic efh);
        exp_t g;
        imem_valid   = v;
        imem_ins     = ins;
        stall_decode = st;
        #1;
        chk({e.tag, ".fetch_hold"}, {31'd0, fetch_hold}, {31'd0, efh});
        if (fetch_hold === 1'b1) hold_seen++;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        chk({g.tag, ".ins1"}, ins1, g.i1);
        chk({g.tag, ".ins2"}, ins2, g.i2);
        chk({g.tag, ".ins3"}, ins3, g.i3);
        chk({g.tag, ".ins4"}, ins4, g.i4);
        chk({g.tag, ".opcode1"}, {25'd0, opcode1}, {25'd0, g.i1[6:0]});
        chk({g.tag, ".opcode2"}, {25'd0, opcode2}, {25'd0, g.i2[6:0]});
        chk({g.tag, ".opcode3"}, {25'd0, opcode3}, {25'd0, g.i3[6:0]});
        chk({g.tag, ".opcode4"}, {25'd0, opcode4}, {25'd0, g.i4[6:0]});
        chk({g.tag, ".ins2_rs1"}, {27'd0, ins2_rs1}, {27'd0, g.i2[19:15]});
        chk({g.tag, ".ins2_rs2"}, {27'd0, ins2_rs2}, {27'd0, g.i2[24:20]});
        chk({g.tag, ".ins3_rs2"}, {27'd0, ins3_rs2}, {27'd0, g.i3[24:20]});
        chk({g.tag, ".ins3_rd"}, {27'd0, ins3_rd}, {27'd0, g.i3[11:7]});
        chk({g.tag, ".ins4_rd"}, {27'd0, ins4_rd}, {27'd0, g.i4[11:7]});
        chk({g.tag, ".bubble_cnt"}, {16'd0, bubble_cnt}, {16'd0, g.bc});
        chk({g.tag, ".flush_cnt"}, {16'd0, flush_cnt}, {16'd0, g.fc});
    endtask

    task automatic mstep(input logic v, input logic [31:0] ins, input logic st,
                         input string tag);
        exp_t e;
        logic fh;
        fh    = !st && model_lu(m1, m2);
        e.tag = tag;
        e.i4  = m3;
        e.i3  = m2;
        e.bc  = mb;
        e.fc  = mf;
        if (st) begin
            e.i2 = c_NOP;
            e.i1 = c_NOP;
            if (mf != 16'hFFFF) e.fc = mf + 16'd1;
        end else if (fh) begin
            e.i2 = c_NOP;
            e.i1 = m1;
            if (mb != 16'hFFFF) e.bc = mb + 16'd1;
        end else begin
            e.i2 = m1;
            e.i1 = v ? ins : c_NOP;
        end
        drive_cycle(v, ins, st, e, fh);
        m1 = e.i1; m2 = e.i2; m3 = e.i3; m4 = e.i4;
        mb = e.bc; mf = e.fc;
    endtask

    task automatic model_reset();
        m1 = c_NOP; m2 = c_NOP; m3 = c_NOP; m4 = c_NOP;
        mb = 16'd0; mf = 16'd0;
    endtask

    initial begin
        exp_t        e;
        logic [15:0] saved_bc;
        int          h0;

        pool[0] = c_LW5;  pool[1] = c_ADD6;  pool[2] = c_SW5;   pool[3] = c_BEQ5;
        pool[4] = c_ADDI7; pool[5] = c_LW0;  pool[6] = c_ADDI1; pool[7] = c_JAL;
        pool[8] = c_JALR5; pool[9] = c_ADD2;

        tbl[0]  = mk(0, c_ADDI1, 0, c_NOP,   c_NOP,   c_NOP,   c_NOP,   16'd0);
        tbl[1]  = mk(0, c_ADD2,  0, c_NOP,   c_NOP,   c_NOP,   c_NOP,   16'd0);
        tbl[2]  = mk(0, c_ADDI1, 0, c_NOP,   c_NOP,   c_NOP,   c_NOP,   16'd0);
        tbl[3]  = mk(0, c_LW5,   0, c_NOP,   c_NOP,   c_NOP,   c_NOP,   16'd0);
        tbl[4]  = mk(1, c_ADDI1, 0, c_ADDI1, c_NOP,   c_NOP,   c_NOP,   16'd0);
        tbl[5]  = mk(1, c_ADD2,  0, c_ADD2,  c_ADDI1, c_NOP,   c_NOP,   16'd0);
        tbl[6]  = mk(0, c_ADD2,  0, c_NOP,   c_ADD2,  c_ADDI1, c_NOP,   16'd0);
        tbl[7]  = mk(0, c_ADDI1, 0, c_NOP,   c_NOP,   c_ADD2,  c_ADDI1, 16'd0);
        tbl[8]  = mk(1, c_JAL,   0, c_JAL,   c_NOP,   c_NOP,   c_ADD2,  16'd0);
        tbl[9]  = mk(1, c_ADDI1, 0, c_ADDI1, c_JAL,   c_NOP,   c_NOP,   16'd0);
        tbl[10] = mk(1, c_ADD2,  1, c_NOP,   c_NOP,   c_JAL,   c_NOP,   16'd1);
        tbl[11] = mk(0, c_ADD2,  0, c_NOP,   c_NOP,   c_NOP,   c_JAL,   16'd1);

        // ---- reset state ----
        rst_n        = 1'b0;
        imem_valid   = 1'b1;
        imem_ins     = c_ADD2;
        stall_decode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ins1", ins1, c_NOP);
        chk("rst.ins2", ins2, c_NOP);
        chk("rst.ins3", ins3, c_NOP);
        chk("rst.ins4", ins4, c_NOP);
        chk("rst.bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("rst.flush_cnt", {16'd0, flush_cnt}, 32'd0);
        chk("rst.fetch_hold", {31'd0, fetch_hold}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- vector table: bubbles, streaming, flush with jal in stage 2 ----
        for (int i = 0; i < 12; i++) begin
            e.i1 = tbl[i].e1; e.i2 = tbl[i].e2; e.i3 = tbl[i].e3; e.i4 = tbl[i].e4;
            e.bc = 16'd0;     e.fc = tbl[i].fc;
            e.tag = $sformatf("tbl%0d", i);
            drive_cycle(tbl[i].v, tbl[i].ins, tbl[i].st, e, 1'b0);
        end
        chk("tbl.no_hold", hold_seen, 0);
        m1 = c_NOP; m2 = c_NOP; m3 = c_NOP; m4 = c_JAL; mb = 16'd0; mf = 16'd1;

        // ---- load-use: lw x5 then add x6,x5,x0 ----
        hold_seen = 0;
        mstep(1, c_LW5,   0, "lu_lw");
        mstep(1, c_ADD6,  0, "lu_add");
        mstep(1, c_ADDI1, 0, "lu_hold");
        if (c_LU_EN) begin
            chk("lu.ins2_bubble", ins2, c_NOP);
            chk("lu.ins3_load", ins3, c_LW5);
            chk("lu.ins1_kept", ins1, c_ADD6);
        end
        mstep(1, c_ADDI1, 0, "lu_after");
        mstep(0, c_ADDI1, 0, "lu_drain");
        chk("lu.hold_cycles", hold_seen, c_LU_EN ? 1 : 0);
        chk("lu.bubble_cnt", {16'd0, bubble_cnt}, c_LU_EN ? 32'd1 : 32'd0);

        // ---- lw x0 never hazards ----
        h0 = hold_seen;
        mstep(1, c_LW0,   0, "lu0_lw");
        mstep(1, c_ADD60, 0, "lu0_add");
        mstep(1, c_ADD2,  0, "lu0_next");
        chk("lu0.no_hold", hold_seen, h0);

        // ---- flush coincident with a load-use hazard ----
        mstep(1, c_LW5,  0, "fl_lw");
        mstep(1, c_ADD6, 0, "fl_add");
        saved_bc = bubble_cnt;
        mstep(1, c_ADD2, 1, "fl_both");
        chk("fl.bubble_unchanged", {16'd0, bubble_cnt}, {16'd0, saved_bc});
        mstep(0, c_ADD2, 0, "fl_drain");

        // ---- asynchronous reset in the middle of a hold ----
        mstep(1, c_LW5,  0, "ar_lw");
        mstep(1, c_ADD6, 0, "ar_add");
        imem_valid   = 1'b1;
        imem_ins     = c_ADDI1;
        stall_decode = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar.ins1", ins1, c_NOP);
        chk("ar.ins2", ins2, c_NOP);
        chk("ar.ins3", ins3, c_NOP);
        chk("ar.ins4", ins4, c_NOP);
        chk("ar.bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("ar.flush_cnt", {16'd0, flush_cnt}, 32'd0);
        chk("ar.fetch_hold", {31'd0, fetch_hold}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mstep(1, c_ADDI1, 0, "ar_first");
        mstep(1, c_ADD2,  0, "ar_second");

        // ---- flush counter saturation ----
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n        = 1'b1;
        stall_decode = 1'b1;
        imem_valid   = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat.flush_pre", {16'd0, flush_cnt}, 32'h0000_FFFE);
        model_reset();
        mf = 16'hFFFE;
        mstep(1, c_ADD2, 1, "sat1");
        mstep(1, c_ADD2, 1, "sat2");
        mstep(1, c_ADD2, 1, "sat3");
        chk("sat.flush_held", {16'd0, flush_cnt}, 32'h0000_FFFF);

        // ---- random stream ----
        for (int i = 0; i < 60; i++) begin
            mstep(($urandom % 5) != 0, pool[$urandom % 10], ($urandom % 8) == 0,
                  $sformatf("rnd%0d", i));
        end

        chk("sbq.empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
